// File: rtl/parking_timer.sv
// Per-slot occupancy and elapsed-time tracker for the parking lot.
// Feeds exit age and a one-cycle exit strobe to the cost calculator.
module parking_timer #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2,
  parameter int TICK_DIV  = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry_pulse,
  input  logic [SLOT_W-1:0]    entry_slot,
  input  logic                 exit_pulse,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic [7:0]           parking_time,
  output logic                 exit_detected,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic [SLOT_W:0]      free_count,
  output logic                 full,
  output logic                 entry_err,
  output logic                 exit_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]        r_presc;
  logic [7:0]           r_age [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_occ;
  logic [SLOT_W:0]      r_free;
  logic                 r_full;
  logic [7:0]           r_ptime;
  logic                 r_exdet;
  logic                 r_ent_err;
  logic                 r_ex_err;

  logic                 w_tick;
  logic [NUM_SLOTS-1:0] w_ent_hit;
  logic [NUM_SLOTS-1:0] w_ex_hit;
  logic [NUM_SLOTS-1:0] w_ent_set;
  logic [NUM_SLOTS-1:0] w_ex_set;
  logic [NUM_SLOTS-1:0] w_occ_nxt;
  logic                 w_ent_ok;
  logic                 w_ex_ok;
  logic [7:0]           w_ex_age;
  logic [SLOT_W:0]      w_free;

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_comb begin
    w_ent_hit = '0;
    w_ex_hit  = '0;
    w_ex_age  = '0;
    w_free    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (entry_slot == SLOT_W'(i)) w_ent_hit[i] = 1'b1;
      if (exit_slot == SLOT_W'(i)) begin
        w_ex_hit[i] = 1'b1;
        w_ex_age    = r_age[i];
      end
    end
    w_ex_ok  = exit_pulse && |(w_ex_hit & r_occ);
    w_ex_set = w_ex_ok ? w_ex_hit : '0;
    // A same-cycle valid exit frees the slot for the entry.
    w_ent_ok  = entry_pulse && |(w_ent_hit & (~r_occ | w_ex_set));
    w_ent_set = w_ent_ok ? w_ent_hit : '0;
    w_occ_nxt = (r_occ & ~w_ex_set) | w_ent_set;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!w_occ_nxt[i]) w_free = w_free + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc   <= '0;
      r_occ     <= '0;
      r_free    <= (SLOT_W + 1)'(NUM_SLOTS);
      r_full    <= 1'b0;
      r_ptime   <= '0;
      r_exdet   <= 1'b0;
      r_ent_err <= 1'b0;
      r_ex_err  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) r_age[i] <= '0;
    end else begin
      r_presc   <= w_tick ? '0 : r_presc + 1'b1;
      r_occ     <= w_occ_nxt;
      r_free    <= w_free;
      r_full    <= (w_free == '0);
      r_exdet   <= w_ex_ok;
      r_ent_err <= entry_pulse & ~w_ent_ok;
      r_ex_err  <= exit_pulse & ~w_ex_ok;
      if (w_ex_ok) r_ptime <= w_ex_age;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_ent_set[i])
          r_age[i] <= '0;
        else if (w_tick && r_occ[i] && r_age[i] != 8'hFF)
          r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end

  assign parking_time  = r_ptime;
  assign exit_detected = r_exdet;
  assign occupied      = r_occ;
  assign free_count    = r_free;
  assign full          = r_full;
  assign entry_err     = r_ent_err;
  assign exit_err      = r_ex_err;

endmodule

// File: tb/tb_parking_timer.sv
// Directed bench for parking_timer with TICK_DIV=4, four slots,
// 3-bit slot index so out-of-range slots can be driven.
module tb_parking_timer;

  localparam int NS = 4;
  localparam int SW = 3;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          entry_pulse = 1'b0;
  logic [SW-1:0] entry_slot = '0;
  logic          exit_pulse = 1'b0;
  logic [SW-1:0] exit_slot = '0;
  logic [7:0]    parking_time;
  logic          exit_detected;
  logic [NS-1:0] occupied;
  logic [SW:0]   free_count;
  logic          full;
  logic          entry_err;
  logic          exit_err;

  int nchk = 0;
  int nerr = 0;
  int edges = 0;

  parking_timer #(
    .NUM_SLOTS(NS),
    .SLOT_W(SW),
    .TICK_DIV(TD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .entry_pulse(entry_pulse),
    .entry_slot(entry_slot),
    .exit_pulse(exit_pulse),
    .exit_slot(exit_slot),
    .parking_time(parking_time),
    .exit_detected(exit_detected),
    .occupied(occupied),
    .free_count(free_count),
    .full(full),
    .entry_err(entry_err),
    .exit_err(exit_err)
  );

  always #5 clk = ~clk;

  // Edge n after reset release carries a tick when n % 4 == 0.
  always @(posedge clk or posedge reset) begin
    if (reset) edges = 0;
    else edges = edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input int es,
                       input logic xn, input int xs);
    entry_pulse = en;
    entry_slot  = SW'(es);
    exit_pulse  = xn;
    exit_slot   = SW'(xs);
    @(negedge clk);
    entry_pulse = 1'b0;
    exit_pulse  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align(input int m);
    while (((edges + 1) % TD) != m) @(negedge clk);
  endtask

  initial begin
    idle(3);
    chk("rst_ptime", parking_time, 0);
    chk("rst_exdet", exit_detected, 0);
    chk("rst_occ", occupied, 0);
    chk("rst_free", free_count, 4);
    chk("rst_full", full, 0);
    chk("rst_eerr", entry_err, 0);
    chk("rst_xerr", exit_err, 0);
    reset = 1'b0;

    // Basic timing: entry on edge 4k+1, exit 20 edges later -> 5 ticks
    align(1);
    drive(1, 1, 0, 0);
    chk("t1_occ_in", occupied, 4'b0010);
    chk("t1_free_in", free_count, 3);
    idle(19);
    drive(0, 0, 1, 1);
    chk("t1_ptime", parking_time, 5);
    chk("t1_exdet", exit_detected, 1);
    chk("t1_occ", occupied, 0);
    chk("t1_free", free_count, 4);
    idle(1);
    chk("t1_exdet_lo", exit_detected, 0);
    chk("t1_ptime_hold", parking_time, 5);

    // Saturation
    drive(1, 0, 0, 0);
    idle(1200);
    drive(0, 0, 1, 0);
    chk("t2_ptime", parking_time, 255);

    // Error paths; entry on tick edge E, re-entry on tick edge E+4
    align(0);
    drive(1, 2, 0, 0);
    idle(3);
    drive(1, 2, 0, 0);
    chk("t3_dup_err", entry_err, 1);
    idle(1);
    chk("t3_dup_err_lo", entry_err, 0);
    drive(0, 0, 1, 3);
    chk("t3_xfree_err", exit_err, 1);
    chk("t3_xfree_det", exit_detected, 0);
    chk("t3_xfree_pt", parking_time, 255);
    drive(1, 5, 0, 0);
    chk("t3_oor_err", entry_err, 1);
    chk("t3_oor_occ", occupied, 4'b0100);
    idle(5);
    drive(0, 0, 1, 2);
    chk("t3_age_kept", parking_time, 3);
    chk("t3_age_det", exit_detected, 1);

    // Full
    for (int s = 0; s < NS; s++) drive(1, s, 0, 0);
    chk("t4_full", full, 1);
    chk("t4_free0", free_count, 0);
    chk("t4_occ", occupied, 4'b1111);
    drive(1, 1, 0, 0);
    chk("t4_fifth_err", entry_err, 1);
    drive(0, 0, 1, 2);
    chk("t4_notfull", full, 0);
    chk("t4_free1", free_count, 1);
    chk("t4_xdet", exit_detected, 1);

    // Same-slot collision on occupied slot 1 with age 7
    drive(0, 0, 1, 1);
    align(0);
    drive(1, 1, 0, 0);
    idle(28);
    drive(1, 1, 1, 1);
    chk("t5_ptime", parking_time, 7);
    chk("t5_exdet", exit_detected, 1);
    chk("t5_occ1", occupied[1], 1);
    chk("t5_eerr", entry_err, 0);
    chk("t5_xerr", exit_err, 0);
    idle(19);
    drive(0, 0, 1, 1);
    chk("t5_age_restart", parking_time, 5);

    // Same-slot collision on free slot 2
    drive(1, 2, 1, 2);
    chk("t5b_occ", occupied, 4'b1101);
    chk("t5b_xerr", exit_err, 1);
    chk("t5b_exdet", exit_detected, 0);
    chk("t5b_eerr", entry_err, 0);
    chk("t5b_free", free_count, 1);

    // Async reset with a valid exit pending
    exit_pulse = 1'b1;
    exit_slot  = SW'(0);
    #2 reset = 1'b1;
    #1;
    chk("t6_occ", occupied, 0);
    chk("t6_free", free_count, 4);
    chk("t6_ptime", parking_time, 0);
    chk("t6_exdet", exit_detected, 0);
    chk("t6_full", full, 0);
    @(negedge clk);
    exit_pulse = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_no_exdet", exit_detected, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/parking_timer.md
Name: parking_timer

Overview:
- Upstream stage of the cost calculator. Tracks occupancy and elapsed parking time for NUM_SLOTS parking slots.
- Slot timing is driven by a prescaled time-unit tick.
- On a valid exit it emits the slot's elapsed time on parking_time with a one-cycle exit_detected pulse. These drive the cost calculator's parking_time/exit_detected inputs directly.
- Also reports occupancy, full status and protocol errors to gate/display logic.

Parameters:
- NUM_SLOTS, 4, number of parking slots (2..16).
- SLOT_W, 2, width of slot index; must satisfy 2**SLOT_W >= NUM_SLOTS.
- TICK_DIV, 1000, clk cycles per parking time unit (>= 2).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- entry_pulse  input  1  single-cycle car-entry event.
- entry_slot  input  SLOT_W  slot index for entry_pulse.
- exit_pulse  input  1  single-cycle car-exit event.
- exit_slot  input  SLOT_W  slot index for exit_pulse.
- parking_time  output  8  elapsed time units of the last exiting car; holds until the next valid exit.
- exit_detected  output  1  one-cycle pulse; parking_time is valid in the same cycle.
- occupied  output  NUM_SLOTS  per-slot occupancy flags.
- free_count  output  SLOT_W+1  number of unoccupied slots.
- full  output  1  high when free_count == 0.
- entry_err  output  1  one-cycle pulse: entry rejected.
- exit_err  output  1  one-cycle pulse: exit rejected.

Behaviour:
- Reset (async, immediate):
  - parking_time=0, exit_detected=0, occupied=0, free_count=NUM_SLOTS, full=0, entry_err=0, exit_err=0.
  - Prescaler=0; all age counters=0.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick is an internal 1-cycle strobe, asserted in the cycle the prescaler equals TICK_DIV-1.
  - Free-running; unaffected by entry/exit events.
- Age counters: one 8-bit counter per slot.
  - On tick, each occupied slot's counter increments, saturating at 255 (no wrap).
  - Unoccupied slots hold their value.
- Entry, sampled on a clk edge with entry_pulse=1:
  - entry_slot >= NUM_SLOTS, or the slot is already occupied: entry_err=1 the next cycle; no state change.
  - Otherwise: occupied[slot] set and the slot's age cleared to 0. Entry clear overrides a same-cycle tick.
- Exit, sampled on a clk edge with exit_pulse=1:
  - exit_slot >= NUM_SLOTS, or the slot is unoccupied: exit_err=1 the next cycle; exit_detected stays 0; parking_time unchanged.
  - Otherwise:
    - parking_time <= that slot's age value before any same-cycle tick increment.
    - exit_detected=1 for exactly the following cycle.
    - occupied[slot] cleared.
- Latency: exactly 1 clk from event sample to exit_detected / entry_err / exit_err assertion. All outputs are registered.
- Simultaneous entry and exit, different slots: both processed independently in the same cycle.
- Simultaneous entry and exit, same slot:
  - Slot occupied: exit processed (reports old age), then entry re-occupies the slot with age=0. Slot ends occupied; no error.
  - Slot unoccupied: entry accepted, exit_err asserted.
- free_count and full: updated in the same cycle as occupied (registered together). Always consistent with popcount(~occupied).
- Reset mid-operation: all slots vacated; any pending pulse is dropped; exit_detected never asserts from pre-reset state.
- exit_detected is never asserted for two consecutive cycles unless valid exits occur on consecutive cycles.

Test Plan:
1. Basic exit timing (TICK_DIV=4, NUM_SLOTS=4): entry slot 1; wait 20 clk (5 ticks); exit slot 1 -> next cycle exit_detected=1, parking_time=5, occupied=4'b0000, free_count=4.
2. Saturation: entry slot 0; wait 300 ticks; exit slot 0 -> parking_time=255.
3. Error paths:
   - entry slot 2 twice -> second entry gives entry_err=1 for 1 cycle, age not cleared.
   - exit slot 3 while free -> exit_err=1, exit_detected=0, parking_time unchanged.
   - entry slot 5 with NUM_SLOTS=4 -> entry_err=1.
4. Full: fill slots 0..3 -> full=1, free_count=0. A fifth entry attempt -> entry_err=1. Exit slot 2 -> full=0, free_count=1.
5. Same-slot collision: slot 1 occupied with age 7; entry_pulse and exit_pulse both on slot 1 in the same cycle -> parking_time=7, exit_detected=1, occupied[1]=1, age restarts at 0.
6. Async reset: assert reset mid-occupancy with an exit_pulse in the same cycle -> all outputs at reset values immediately; no exit_detected after reset deasserts.
